// File: rtl/alu_arb3.sv
// alu_arb3: three-way round-robin arbiter with hold limit, registering the granted requester's operand.
module alu_arb3 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] i0,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  output logic [2:0]  gnt,
  output logic [1:0]  sel,
  output logic [31:0] out,
  output logic        out_vld,
  output logic        busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] MAX = MAX_HOLD[7:0];
  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d, sel_q, sel_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [31:0] out_q, out_d;
  logic        vld_q, vld_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  c1, c2, pick;
  logic [31:0] opnd;
  logic        xfer;
  always_comb begin
    c1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    c2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    pick = req[c1] ? c1 : req[c2] ? c2 : ptr_q;
    opnd = (sel_q == 2'd0) ? i0 : (sel_q == 2'd1) ? i1 : i2;
    xfer = (state_q == GRANT) && req[sel_q];
    cnt_inc = cnt_q + 8'd1;
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    gnt_d = gnt_q;
    out_d = out_q;
    cnt_d = cnt_q;
    vld_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = (req != 3'b000) ? GRANT : IDLE;
      gnt_d = (req != 3'b000) ? 3'b001 << pick : 3'b000;
      sel_d = (req != 3'b000) ? pick : 2'd0;
      ptr_d = (req != 3'b000) ? pick : ptr_q;
      cnt_d = 8'd0;
    end else if (xfer) begin
      out_d = opnd;
      vld_d = 1'b1;
      cnt_d = cnt_inc;
      state_d = (cnt_inc == MAX) ? IDLE : GRANT;
      gnt_d = (cnt_inc == MAX) ? 3'b000 : gnt_q;
      sel_d = (cnt_inc == MAX) ? 2'd0 : sel_q;
    end else begin
      state_d = IDLE;
      gnt_d = 3'b000;
      sel_d = 2'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 2'd2;
      sel_q <= 2'd0;
      gnt_q <= 3'b000;
      out_q <= 32'd0;
      vld_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign out = out_q;
  assign out_vld = vld_q;
  assign busy = (state_q == GRANT);
endmodule

// File: doc/alu_arb3.md
ALU_ARB3 -- requirements
Module: alu_arb3

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum transfers per grant; SHALL be legal in range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  per-requester request; bit k belongs to requester k.
REQ-005 i0, i1, i2  input  32 each  operand offered by requester 0, 1, 2.
REQ-006 gnt  output  3  registered one-hot grant; all-zero when idle.
REQ-007 sel  output  2  index of the granted requester, for the shared 3:1 operand mux; SHALL be 0 when idle and SHALL never be 3.
REQ-008 out  output  32  registered operand of the last transfer.
REQ-009 out_vld  output  1  registered; high for the one cycle after each transfer.
REQ-010 busy  output  1  high while in GRANT.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 Rotating pointer ptr (2 bits, values 0..2) SHALL hold the index of the last granted requester.
REQ-013 Search order SHALL be (ptr+1) mod 3, then (ptr+2) mod 3, then ptr.
REQ-014 IDLE, req != 0 at an edge: SHALL enter GRANT.
  - gnt set to the one-hot code of the first requesting index in search order.
  - sel set to that index; ptr set to that index; hold counter cleared.
REQ-015 IDLE, req == 0: SHALL stay in IDLE with gnt=0 and sel=0.
REQ-016 Transfer definition: any edge in GRANT at which req[sel]=1.
REQ-017 Each transfer SHALL register the selected operand into out, set out_vld=1 for the following cycle, and increment the hold counter.
REQ-018 Edges without a transfer SHALL drive out_vld=0; out SHALL hold its value.
REQ-019 GRANT with req[sel]=0 at an edge: SHALL return to IDLE.
  - gnt=0 and sel=0 at that edge; no transfer.
REQ-020 Transfer that brings the hold count to MAX_HOLD: SHALL return to IDLE at that same edge.
  - gnt=0 at that edge.
  - gnt is high for at most MAX_HOLD cycles per grant.
REQ-021 Every grant SHALL be followed by at least one IDLE cycle; re-arbitration occurs only from IDLE.
REQ-022 The hold counter SHALL be 8 bits wide and SHALL never exceed MAX_HOLD.
REQ-023 Changes on requests other than req[sel] during GRANT SHALL have no effect until the next arbitration.
REQ-024 Operand values SHALL be sampled only at transfer edges.
REQ-025 busy SHALL equal (state == GRANT); gnt SHALL be non-zero exactly when busy=1.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of state or an in-progress grant:
  - state=IDLE, gnt=0, sel=0, out=0, out_vld=0, busy=0, hold counter=0.
  - ptr=2, so requester 0 has first priority after reset.
REQ-027 After rst_n rises, the first arbitration SHALL occur at the first rising edge that sees req != 0.

Verification
REQ-028 Reset mid-grant: rst_n pulled low while gnt=010 -> gnt=000, out_vld=0, out=0 before the next edge. Then req=111 after release -> first gnt=001.
REQ-029 Single requester, MAX_HOLD=8: req[1] high for 4 cycles with i1=A,B,C then dropped.
  - gnt=010 and sel=1 from edge 1.
  - out_vld high 3 cycles with out=A, B, C.
  - gnt=000 at the edge that sees req[1]=0.
REQ-030 Fairness, MAX_HOLD=2, req=111 held constant:
  - grant sequence 001, 010, 100, 001.
  - each grant is 2 cycles long with 1 IDLE cycle between grants.
  - 2 out_vld pulses per grant.
REQ-031 Rotation: requester 0 granted and released, then req=101 -> next gnt=100, not 001.
REQ-032 MAX_HOLD=1, req=001 held -> gnt alternates 001 and 000 every cycle, out_vld high every other cycle.
REQ-033 Boundary: req[sel] drops on the same edge the count would reach MAX_HOLD -> no transfer, out_vld=0, IDLE entered once, gnt=000.
